dynamic_limiter: RTL

//  Gain-reducing counterpart of the overdrive stage. Tracks signal envelope (attack/release

---
 rtl/dynamic_limiter_if.sv | 25 ++
 rtl/dynamic_limiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dynamic_limiter_if.sv
// rtl/dynamic_limiter_if.sv - sample-path handshake bundle for the dynamic limiter
// master drives samples in and observes results; slave is the limiter side.
interface dynamic_limiter_if;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               in_ready;
  logic signed [15:0] sample_out;
  logic               out_valid;

  modport master (
    output sample_in,
    output sample_valid,
    input  in_ready,
    input  sample_out,
    input  out_valid
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output in_ready,
    output sample_out,
    output out_valid
  );
endinterface

// File: rtl/dynamic_limiter.sv
// rtl/dynamic_limiter.sv - envelope-following limiter with restoring-divider gain
// Scales each sample by threshold/envelope once the envelope exceeds threshold.
module dynamic_limiter #(
  parameter int GAIN_FRAC = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  dynamic_limiter_if.slave     s,
  input  logic [14:0]          threshold,
  input  logic [3:0]           attack_shift,
  input  logic [3:0]           release_shift,
  input  logic                 bypass,
  output logic [GAIN_FRAC:0]   gain_out,
  output logic                 overrun
);

  localparam int PW = 17 + GAIN_FRAC + 2;
  localparam int CW = $clog2(GAIN_FRAC + 1);
  localparam logic [GAIN_FRAC:0] UNITY = {1'b1, {GAIN_FRAC{1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(GAIN_FRAC);
  localparam logic signed [PW-1:0] SAT_HI = PW'(32767);
  localparam logic signed [PW-1:0] SAT_LO = -PW'(32768);

  typedef enum logic [2:0] {IDLE, ENV, DIV, APPLY, DONE} state_t;

  state_t                   state_q;
  logic signed [15:0]       x_q;
  logic [14:0]              mag_q;
  logic [14:0]              env_q;
  logic [14:0]              rem_q;
  logic                     thr0_q;
  logic [CW-1:0]            cnt_q;
  logic [GAIN_FRAC:0]       gain_q;
  logic signed [15:0]       sample_out_q;
  logic                     out_valid_q;
  logic [GAIN_FRAC:0]       gain_out_q;
  logic                     overrun_q;

  logic [14:0]              mag_d;
  logic signed [15:0]       diff;
  logic [14:0]              abs_d;
  logic [14:0]              step_raw;
  logic [14:0]              step;
  logic [14:0]              env_d;
  logic [15:0]              trial;
  logic                     ge;
  logic [14:0]              rem_d;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     g_ext;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;
  logic signed [15:0]       sat;

  assign s.in_ready   = (state_q == IDLE);
  assign s.sample_out = sample_out_q;
  assign s.out_valid  = out_valid_q;
  assign gain_out     = gain_out_q;
  assign overrun      = overrun_q;

  // -32768 has no positive 16-bit counterpart, so its magnitude clips to 32767
  always_comb begin
    mag_d = s.sample_in[14:0];
    if (s.sample_in[15]) begin
      mag_d = (s.sample_in == 16'sh8000) ? 15'h7fff : 15'(-s.sample_in);
    end
  end

  always_comb begin
    diff     = $signed({1'b0, mag_q}) - $signed({1'b0, env_q});
    abs_d    = diff[15] ? 15'(-diff) : diff[14:0];
    step_raw = diff[15] ? (abs_d >> release_shift) : (abs_d >> attack_shift);
    step     = (step_raw == 15'd0) ? 15'd1 : step_raw;
    env_d    = env_q;
    if (diff > 16'sd0) begin
      env_d = env_q + step;
    end else if (diff < 16'sd0) begin
      env_d = env_q - step;
    end
  end

  // First divider step shifts in threshold[0]; threshold<env makes that bit 0, so
  // GAIN_FRAC+1 steps give exactly the quotient of (threshold<<GAIN_FRAC)/env.
  always_comb begin
    trial = {rem_q, (cnt_q == '0) ? thr0_q : 1'b0};
    ge    = (trial >= {1'b0, env_q});
    rem_d = ge ? 15'(trial - {1'b0, env_q}) : trial[14:0];
  end

  always_comb begin
    x_ext   = {{(PW-16){x_q[15]}}, x_q};
    g_ext   = {{(PW-GAIN_FRAC-1){1'b0}}, gain_q};
    prod    = x_ext * g_ext;
    shifted = prod >>> GAIN_FRAC;
    sat     = shifted[15:0];
    if (shifted > SAT_HI) begin
      sat = 16'sh7fff;
    end else if (shifted < SAT_LO) begin
      sat = 16'sh8000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      mag_q        <= '0;
      env_q        <= '0;
      rem_q        <= '0;
      thr0_q       <= 1'b0;
      cnt_q        <= '0;
      gain_q       <= UNITY;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      gain_out_q   <= UNITY;
      overrun_q    <= 1'b0;
    end else begin
      if (s.sample_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (s.sample_valid) begin
            x_q     <= s.sample_in;
            mag_q   <= mag_d;
            state_q <= ENV;
          end
        end
        ENV: begin
          env_q  <= env_d;
          rem_q  <= {1'b0, threshold[14:1]};
          thr0_q <= threshold[0];
          cnt_q  <= '0;
          if (bypass || (env_d <= threshold)) begin
            gain_q  <= UNITY;
            state_q <= APPLY;
          end else begin
            gain_q  <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q  <= rem_d;
          gain_q <= {gain_q[GAIN_FRAC-1:0], ge};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= APPLY;
          end
        end
        APPLY: begin
          sample_out_q <= sat;
          gain_out_q   <= gain_q;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
